// File: rtl/usb_phy_pkg.sv
// Shared USB full-speed receive definitions: line-state encodings,
// receiver state enum, default timing parameters and NRZI helper.
package usb_phy_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ABORT = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE_DEF  = 4;
    localparam int STUFF_LIMIT_DEF = 6;
    localparam int HUNT_STROBES    = 8;
    localparam int ABORT_J_STROBES = 8;

    localparam logic [3:0] SYNC_TAIL = 4'b0001;

    function automatic logic nrzi_bit(line_state_e cur, line_state_e prev);
        return cur == prev;
    endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Line-state synchronizer and bit-phase recovery: the phase counter
// re-aligns on every line transition and strobes mid-bit.
module usb_rx_dpll
    import usb_phy_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  line_state_i,
    output line_state_e line_o,
    output logic        strobe_o
);

    localparam int PW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);

    line_state_e     sync1_q;
    line_state_e     sync2_q;
    line_state_e     last_q;
    logic [PW-1:0]   phase_q;
    logic [PW-1:0]   phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= LS_J;
            sync2_q <= LS_J;
            last_q  <= LS_J;
            phase_q <= '0;
        end else begin
            sync1_q <= line_state_e'(line_state_i);
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
            phase_d = '0;
        end
        if (sync2_q != last_q) begin
            phase_d = '0;
        end
    end

    assign line_o   = sync2_q;
    assign strobe_o = (phase_q == PH_MID);

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive path: SYNC hunt, NRZI decode, bit unstuffing,
// byte assembly and EOP / error detection.
module usb_rx_decoder
    import usb_phy_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] line_state,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic       eop
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
    localparam logic [2:0] HUNT_LAST  = 3'(HUNT_STROBES - 1);
    localparam logic [2:0] ABORT_LAST = 3'(ABORT_J_STROBES - 1);

    line_state_e line_s;
    logic        strobe;

    usb_rx_dpll #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_dpll (
        .clk          (clk),
        .rst          (rst),
        .line_state_i (line_state),
        .line_o       (line_s),
        .strobe_o     (strobe)
    );

    rx_state_e     state_q,   state_d;
    line_state_e   prev_q,    prev_d;
    logic [3:0]    hist_q,    hist_d;
    logic [2:0]    hunt_q,    hunt_d;
    logic [OW-1:0] ones_q,    ones_d;
    logic [2:0]    bitcnt_q,  bitcnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    data_q,    data_d;
    logic          se0_q,     se0_d;
    logic [2:0]    jcnt_q,    jcnt_d;
    logic          valid_q,   valid_d;
    logic          active_q,  active_d;
    logic          err_q,     err_d;
    logic          eop_q,     eop_d;
    logic          bit_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= LS_J;
            hist_q   <= 4'hF;
            hunt_q   <= '0;
            ones_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            se0_q    <= 1'b0;
            jcnt_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            hist_q   <= hist_d;
            hunt_q   <= hunt_d;
            ones_q   <= ones_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            se0_q    <= se0_d;
            jcnt_q   <= jcnt_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            err_q    <= err_d;
            eop_q    <= eop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        hist_d   = hist_q;
        hunt_d   = hunt_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        se0_d    = se0_q;
        jcnt_d   = jcnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        eop_d    = 1'b0;
        bit_v    = nrzi_bit(line_s, prev_q);

        if (strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    // The first K is itself the leading SYNC zero.
                    if (rx_en && line_s == LS_K) begin
                        state_d = ST_HUNT;
                        prev_d  = LS_K;
                        hist_d  = 4'b1110;
                        hunt_d  = '0;
                    end
                end
                ST_HUNT: begin
                    unique case (line_s)
                        LS_SE1: begin
                            err_d   = 1'b1;
                            state_d = ST_ABORT;
                            jcnt_d  = '0;
                        end
                        LS_SE0: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            prev_d = line_s;
                            hist_d = {hist_q[2:0], bit_v};
                            if (hist_d == SYNC_TAIL) begin
                                state_d  = ST_DATA;
                                ones_d   = '0;
                                bitcnt_d = '0;
                                se0_d    = 1'b0;
                            end else if (hunt_q == HUNT_LAST) begin
                                state_d = ST_IDLE;
                            end else begin
                                hunt_d = hunt_q + 1'b1;
                            end
                        end
                    endcase
                end
                ST_DATA: begin
                    if (line_s == LS_SE1) begin
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                        jcnt_d  = '0;
                    end else if (se0_q) begin
                        if (line_s == LS_J) begin
                            eop_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (line_s == LS_K) begin
                            err_d   = 1'b1;
                            state_d = ST_ABORT;
                            jcnt_d  = '0;
                        end
                    end else if (line_s == LS_SE0) begin
                        if (bitcnt_q != '0) begin
                            err_d   = 1'b1;
                            state_d = ST_ABORT;
                            jcnt_d  = '0;
                        end else begin
                            se0_d = 1'b1;
                        end
                    end else begin
                        prev_d = line_s;
                        if (ones_q == ONES_MAX) begin
                            // Stuffed zero is dropped; a one here is a violation.
                            ones_d = '0;
                            if (bit_v) begin
                                err_d   = 1'b1;
                                state_d = ST_ABORT;
                                jcnt_d  = '0;
                            end
                        end else begin
                            ones_d   = bit_v ? ones_q + 1'b1 : '0;
                            shift_d  = {bit_v, shift_q[7:1]};
                            bitcnt_d = bitcnt_q + 1'b1;
                            if (bitcnt_q == 3'd7) begin
                                data_d  = shift_d;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ABORT: begin
                    if (line_s == LS_J) begin
                        if (jcnt_q == ABORT_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            jcnt_d = jcnt_q + 1'b1;
                        end
                    end else begin
                        jcnt_d = '0;
                        if (line_s == LS_SE1) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (!rx_en) begin
            state_d = ST_IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
            eop_d   = 1'b0;
        end
        if (err_d) begin
            eop_d = 1'b0;
        end
        active_d = (state_d == ST_DATA);
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_active = active_q;
    assign rx_error  = err_q;
    assign eop       = eop_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI/stuffing encoder drives
// packets; a negedge monitor tallies output pulses.
module tb_usb_rx_decoder;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] line_state = 2'b01;
    logic       rx_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic       eop;

    usb_rx_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .line_state (line_state),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .rx_error   (rx_error),
        .eop        (eop)
    );

    always #10 clk = ~clk;

    int         n_valid = 0;
    int         n_err   = 0;
    int         n_eop   = 0;
    int         n_act   = 0;
    int         n_both  = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid   <= n_valid + 1;
                last_data <= rx_data;
            end
            if (rx_error) n_err <= n_err + 1;
            if (eop) n_eop <= n_eop + 1;
            if (rx_active) n_act <= n_act + 1;
            if (rx_error && eop) n_both <= n_both + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [1:0] lvl = 2'b01;
    int         enc_ones = 0;
    int         s_v, s_e, s_p, s_a;

    task automatic snap();
        s_v = n_valid;
        s_e = n_err;
        s_p = n_eop;
        s_a = n_act;
    endtask

    task automatic put(input logic [1:0] v, input int n);
        #1 line_state = v;
        repeat (4 * n) @(posedge clk);
    endtask

    task automatic dbit(input logic b);
        if (!b) lvl = (lvl == J) ? K : J;
        put(lvl, 1);
    endtask

    task automatic idle(input int n);
        lvl = J;
        put(J, n);
    endtask

    task automatic send_sync(input bit short_sync);
        lvl = J;
        enc_ones = 0;
        repeat (short_sync ? 3 : 7) dbit(1'b0);
        dbit(1'b1);
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            dbit(d[i]);
            enc_ones = d[i] ? enc_ones + 1 : 0;
            if (enc_ones == 6) begin
                dbit(1'b0);
                enc_ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        put(SE0, 2);
        lvl = J;
        put(J, 1);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        bit         short_sync;
        int         exp_nv;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic run_pkt(input string nm, input vec_t v);
        snap();
        send_sync(v.short_sync);
        send_bits(v.b0, 8);
        if (v.nb == 2) send_bits(v.b1, 8);
        send_eop();
        idle(3);
        chk({nm, "_valid"}, n_valid - s_v, v.exp_nv);
        chk({nm, "_data"}, int'(last_data), int'(v.exp_data));
        chk({nm, "_port"}, int'(rx_data), int'(v.exp_data));
        chk({nm, "_err"}, n_err - s_e, 0);
        chk({nm, "_eop"}, n_eop - s_p, 1);
        chk({nm, "_act_seen"}, int'(n_act > s_a), 1);
        chk({nm, "_act_low"}, int'(rx_active), 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 1, 1'b0, 1, 8'hA5};
        vecs[1] = '{8'hFF, 8'h00, 1, 1'b0, 1, 8'hFF};
        vecs[2] = '{8'h00, 8'h00, 1, 1'b0, 1, 8'h00};
        vecs[3] = '{8'h3C, 8'h00, 1, 1'b0, 1, 8'h3C};
        vecs[4] = '{8'h7E, 8'h81, 2, 1'b0, 2, 8'h81};
        vecs[5] = '{8'hFF, 8'hFF, 2, 1'b0, 2, 8'hFF};
        vecs[6] = '{8'h5A, 8'h00, 1, 1'b1, 1, 8'h5A};
        vecs[7] = '{8'hC3, 8'h00, 1, 1'b0, 1, 8'hC3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_active", int'(rx_active), 0);
        chk("rst_error", int'(rx_error), 0);
        chk("rst_eop", int'(eop), 0);
        rst = 1'b0;
        @(posedge clk);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            run_pkt($sformatf("pkt%0d", i), vecs[i]);
        end

        // Seven equal bit periods after SYNC: stuffing violation.
        snap();
        send_sync(1'b0);
        repeat (7) dbit(1'b1);
        idle(3);
        chk("stuff_err", n_err - s_e, 1);
        chk("stuff_valid", n_valid - s_v, 0);
        chk("stuff_eop", n_eop - s_p, 0);
        chk("stuff_act", int'(rx_active), 0);
        snap();
        send_sync(1'b0);
        send_bits(8'h5A, 8);
        send_eop();
        idle(10);
        chk("abort_hold_valid", n_valid - s_v, 0);
        chk("abort_hold_act", n_act - s_a, 0);
        run_pkt("after_abort", vecs[6]);

        snap();
        send_sync(1'b0);
        send_bits(8'h05, 3);
        put(SE1, 1);
        idle(10);
        chk("se1_err", n_err - s_e, 1);
        chk("se1_valid", n_valid - s_v, 0);
        chk("se1_eop", n_eop - s_p, 0);
        chk("se1_act", int'(rx_active), 0);

        snap();
        send_sync(1'b0);
        send_bits(8'h15, 5);
        send_eop();
        idle(10);
        chk("se0_err", n_err - s_e, 1);
        chk("se0_eop", n_eop - s_p, 0);
        chk("se0_valid", n_valid - s_v, 0);

        snap();
        send_sync(1'b0);
        send_bits(8'h3C, 4);
        @(negedge clk);
        rst = 1'b1;
        line_state = J;
        #1;
        chk("mid_rst_data", int'(rx_data), 0);
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_active", int'(rx_active), 0);
        chk("mid_rst_error", int'(rx_error), 0);
        chk("mid_rst_eop", int'(eop), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        idle(4);
        chk("mid_rst_pulses", (n_valid - s_v) + (n_err - s_e) + (n_eop - s_p), 0);
        run_pkt("post_rst", vecs[3]);

        snap();
        send_sync(1'b0);
        send_bits(8'h96, 4);
        #1 rx_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("en_low_act", int'(rx_active), 0);
        @(posedge clk);
        send_bits(8'h09, 4);
        send_eop();
        idle(3);
        chk("en_low_pulses", (n_valid - s_v) + (n_err - s_e) + (n_eop - s_p), 0);
        #1 rx_en = 1'b1;
        idle(2);
        run_pkt("en_back", vecs[0]);

        chk("err_eop_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
